// File: rtl/mix_columns_ctrl.sv
// mix_columns_ctrl
//   Iterative AES MixColumns engine. It captures a 128-bit state, runs one
//   shared 4-byte column datapath over columns 0..3 (one column per cycle),
//   then holds the result until the downstream side takes it.
//
//   Optional build macro: MIXCOL_INV_EN
//     defined   -> port inv exists; inv=1 at accept selects InvMixColumns
//     undefined -> forward MixColumns only, no inv port
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   state_in (and inv) valid
//   in_ready   block can accept a state (IDLE only)
//   state_in   AES state, byte k = state_in[127-8k -: 8], column c = bytes 4c..4c+3
//   inv        1 = inverse transform (MIXCOL_INV_EN only)
//   out_valid  state_out holds a completed result (DONE only)
//   out_ready  downstream accepts state_out
//   state_out  working register, same byte order as state_in
//   busy       high in BUSY or DONE
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for in_valid; in_ready=1
// BUSY  | transforming column col each cycle, col 0 first
// DONE  | result held on state_out with out_valid=1 until out_ready
module mix_columns_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
`ifdef MIXCOL_INV_EN
  input  logic         inv,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]   state_q;
  logic [1:0]   col_q;
  logic [127:0] work_q;
  logic [127:0] work_nxt;
  logic [31:0]  col_in;
  logic [31:0]  col_out;
  logic [31:0]  col_fwd;
  logic [7:0]   a0, a1, a2, a3;

  function automatic logic [7:0] mul2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul3(input logic [7:0] b);
    return mul2(b) ^ b;
  endfunction

  always_comb begin
    col_in = work_q[127:96];
    case (col_q)
      2'd0: col_in = work_q[127:96];
      2'd1: col_in = work_q[95:64];
      2'd2: col_in = work_q[63:32];
      2'd3: col_in = work_q[31:0];
      default: col_in = work_q[127:96];
    endcase
  end

  assign a0 = col_in[31:24];
  assign a1 = col_in[23:16];
  assign a2 = col_in[15:8];
  assign a3 = col_in[7:0];

  assign col_fwd = {mul2(a0) ^ mul3(a1) ^ a2 ^ a3,
                    a0 ^ mul2(a1) ^ mul3(a2) ^ a3,
                    a0 ^ a1 ^ mul2(a2) ^ mul3(a3),
                    mul3(a0) ^ a1 ^ a2 ^ mul2(a3)};

`ifdef MIXCOL_INV_EN
  logic         mode_q;
  logic [31:0]  col_inv;
  logic [7:0]   x2 [4];
  logic [7:0]   x4 [4];
  logic [7:0]   x8 [4];
  logic [7:0]   m9 [4];
  logic [7:0]   mb [4];
  logic [7:0]   md [4];
  logic [7:0]   me [4];
  logic [7:0]   ab [4];

  assign ab[0] = a0;
  assign ab[1] = a1;
  assign ab[2] = a2;
  assign ab[3] = a3;

  // 9/B/D/E multiples from a doubling chain so only mul2 blocks are used.
  for (genvar i = 0; i < 4; i++) begin : g_inv_mul
    assign x2[i] = mul2(ab[i]);
    assign x4[i] = mul2(x2[i]);
    assign x8[i] = mul2(x4[i]);
    assign m9[i] = x8[i] ^ ab[i];
    assign mb[i] = x8[i] ^ x2[i] ^ ab[i];
    assign md[i] = x8[i] ^ x4[i] ^ ab[i];
    assign me[i] = x8[i] ^ x4[i] ^ x2[i];
  end

  assign col_inv = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                    m9[0] ^ me[1] ^ mb[2] ^ md[3],
                    md[0] ^ m9[1] ^ me[2] ^ mb[3],
                    mb[0] ^ md[1] ^ m9[2] ^ me[3]};

  assign col_out = mode_q ? col_inv : col_fwd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= 1'b0;
    end else if (state_q == ST_IDLE && in_valid) begin
      mode_q <= inv;
    end
  end
`else
  assign col_out = col_fwd;
`endif

  always_comb begin
    work_nxt = work_q;
    case (col_q)
      2'd0: work_nxt[127:96] = col_out;
      2'd1: work_nxt[95:64]  = col_out;
      2'd2: work_nxt[63:32]  = col_out;
      2'd3: work_nxt[31:0]   = col_out;
      default: work_nxt = work_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      col_q   <= 2'd0;
      work_q  <= 128'h0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            work_q  <= state_in;
            col_q   <= 2'd0;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          work_q <= work_nxt;
          col_q  <= col_q + 2'd1;
          if (col_q == 2'd3) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_BUSY) || (state_q == ST_DONE);
  assign state_out = work_q;

endmodule

// File: tb/tb_mix_columns_ctrl.sv
module tb_mix_columns_ctrl;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;
  logic         busy;
`ifdef MIXCOL_INV_EN
  logic         inv;
`endif

  int total;
  int bad;

  mix_columns_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state_in  (state_in),
`ifdef MIXCOL_INV_EN
    .inv       (inv),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_out (state_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] din;
    logic [127:0] dexp;
    string        name;
  } vec_t;

  // Reference model: generic GF(2^8) multiply by shift-and-add, applied as
  // a circulant matrix over each column.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input logic inv_m);
    logic [7:0]   coef [4];
    logic [7:0]   bi   [16];
    logic [7:0]   bo   [16];
    logic [127:0] r = '0;
    if (inv_m) begin
      coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    end else begin
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    end
    for (int k = 0; k < 16; k++) bi[k] = s[127-8*k -: 8];
    for (int c = 0; c < 4; c++) begin
      for (int rr = 0; rr < 4; rr++) begin
        bo[4*c+rr] = 8'h00;
        for (int j = 0; j < 4; j++) bo[4*c+rr] ^= gmul(bi[4*c+j], coef[(j-rr)&3]);
      end
    end
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = bo[k];
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: accept, check 4-edge latency, optional stall, result, return to IDLE.
  task automatic run_op(input string name, input logic [127:0] din, input logic mode,
                        input logic [127:0] dexp, input int stall);
    int lat;
    check({name, " in_ready before accept"}, 128'(in_ready), 128'(1));
    state_in = din;
    in_valid = 1'b1;
    out_ready = (stall == 0);
`ifdef MIXCOL_INV_EN
    inv = mode;
`endif
    step();
    in_valid = 1'b0;
`ifdef MIXCOL_INV_EN
    inv = ~mode;
`endif
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check({name, " latency"}, 128'(lat), 128'(4));
    check({name, " result"}, state_out, dexp);
    for (int i = 0; i < stall; i++) begin
      if (i == stall - 1) out_ready = 1'b1;
      step();
    end
    if (stall == 0) step();
    check({name, " back to idle"}, 128'({in_ready, out_valid, busy}), 128'(3'b100));
    out_ready = 1'b1;
  endtask

  vec_t vecs [4];

  initial begin
    logic [127:0] held;
    logic [127:0] rs;
    logic [127:0] exp_q [$];
    logic [127:0] ins [3];
    int acc_cyc [$];
    int cyc, idx, nout;
    logic pend;

    total = 0;
    bad = 0;
    vecs[0] = '{128'hd4bf5d30e0b452aeb84111f11e2798e5, 128'h046681e5e0cb199a48f8d37a2806264c, "fips"};
    vecs[1] = '{128'hdb135345010101010101010101010101, 128'h8e4da1bc010101010101010101010101, "col db"};
    vecs[2] = '{128'hc6c6c6c6c6c6c6c6c6c6c6c6c6c6c6c6, 128'hc6c6c6c6c6c6c6c6c6c6c6c6c6c6c6c6, "col c6"};
    vecs[3] = '{128'hf20a225cf20a225cf20a225cf20a225c, 128'h9fdc589d9fdc589d9fdc589d9fdc589d, "col f2"};

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    state_in = '0;
`ifdef MIXCOL_INV_EN
    inv = 1'b0;
`endif
    #12;
    check("reset outputs", {in_ready, out_valid, busy}, 3'b100);
    check("reset state_out", state_out, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors; the first accept lands on the first edge after release.
    for (int i = 0; i < 4; i++) run_op(vecs[i].name, vecs[i].din, 1'b0, vecs[i].dexp, 0);

    // Backpressure: hold 10 cycles, in_valid pulses must be ignored.
    state_in = vecs[1].din;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 20 && !out_valid; i++) step();
    out_ready = 1'b0;
    held = state_out;
    check("bp first result", held, vecs[1].dexp);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      state_in = {$urandom, $urandom, $urandom, $urandom};
      step();
      check("bp hold flags", {in_ready, out_valid, busy}, 3'b011);
      check("bp hold data", state_out, held);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    check("bp release", {in_ready, out_valid, busy}, 3'b100);

    // Reset two edges after accept.
    state_in = vecs[0].din;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("mid reset flags", {in_ready, out_valid, busy}, 3'b100);
    check("mid reset data", state_out, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after reset", vecs[3].din, 1'b0, vecs[3].dexp, 0);

`ifdef MIXCOL_INV_EN
    run_op("inverse", 128'h046681e5e0cb199a48f8d37a2806264c, 1'b1,
           128'hd4bf5d30e0b452aeb84111f11e2798e5, 0);
`endif

    // Random states with random downstream stalls against the model.
    for (int i = 0; i < 16; i++) begin
      logic m;
      rs = {$urandom, $urandom, $urandom, $urandom};
`ifdef MIXCOL_INV_EN
      m = 1'($urandom_range(0, 1));
`else
      m = 1'b0;
`endif
      run_op("random", rs, m, model(rs, m), int'($urandom_range(0, 3)));
    end

    // Back-to-back transfers with in_valid and out_ready held high.
    for (int i = 0; i < 3; i++) begin
      ins[i] = {$urandom, $urandom, $urandom, $urandom};
      exp_q.push_back(model(ins[i], 1'b0));
    end
`ifdef MIXCOL_INV_EN
    inv = 1'b0;
`endif
    idx = 0;
    nout = 0;
    cyc = 0;
    state_in = ins[0];
    in_valid = 1'b1;
    out_ready = 1'b1;
    while (nout < 3 && cyc < 100) begin
      pend = in_ready && in_valid;
      if (out_valid) begin
        check("b2b result", state_out, exp_q.pop_front());
        nout++;
      end
      step();
      cyc++;
      if (pend) begin
        acc_cyc.push_back(cyc);
        idx++;
        if (idx < 3) state_in = ins[idx];
        else in_valid = 1'b0;
      end
    end
    check("b2b outputs", 128'(nout), 128'(3));
    check("b2b accepts", 128'(acc_cyc.size()), 128'(3));
    if (acc_cyc.size() == 3) begin
      check("b2b gap min", 128'(acc_cyc[1] - acc_cyc[0] >= 5), 128'(1));
      check("b2b gap even", 128'(acc_cyc[2] - acc_cyc[1]), 128'(acc_cyc[1] - acc_cyc[0]));
    end
    in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
